// File: rtl/lfsr_pkg.sv
// Shared constants, tap table, FSM encoding and elaboration helpers for the LFSR stream.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_fsm_e;

    function automatic logic [31:0] all_ones(input int width);
        return {32{1'b1}} >> (32 - width);
    endfunction

    function automatic int tap_popcount(input logic [31:0] taps);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt += int'(taps[i]);
        end
        return cnt;
    endfunction

    // Maximal-length XNOR tap masks; bit i set means state[i] feeds the XNOR
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One XNOR Fibonacci LFSR shift: feedback enters at bit 0, state shifts toward the MSB.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic fb;

    assign fb  = ~^(cur & TAPS);
    assign nxt = {cur[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_prng_stream.sv
// LFSR PRNG word stream with run enable, seed load and lock-up replacement; LFSR_PERIOD_MON_EN adds a period monitor.
// Latency: out_valid rises one cycle after en is sampled; each handshake shows the next word the following cycle.
// Backpressure: out_data/out_valid hold while out_ready is low; only seed_load retracts valid.
module lfsr_prng_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup_fix
`ifdef LFSR_PERIOD_MON_EN
    ,
    output logic             period_wrap,
    output logic [WIDTH:0]   period_cnt
`endif
);

    localparam logic [31:0]      ONES32 = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] LOCKUP = ONES32[WIDTH-1:0];

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_prng_stream: WIDTH must be 3..32");
    end
    if (tap_popcount(32'(TAPS)) % 2 != 0) begin : g_bad_taps
        $error("lfsr_prng_stream: TAPS popcount must be even");
    end
    if (SEED == LOCKUP) begin : g_bad_seed
        $error("lfsr_prng_stream: SEED must not be the all-ones lock-up state");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_prng_stream: STEPS must be 1..WIDTH");
    end

    lfsr_fsm_e        fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_fix_q, lockup_fix_d;
    logic             hs;
    logic [WIDTH-1:0] load_val;
    logic [STEPS:0][WIDTH-1:0] step_chain;

    assign step_chain[0] = state_q;
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
            .cur (step_chain[gi]),
            .nxt (step_chain[gi+1])
        );
    end

    assign out_valid  = (fsm_q == RUN);
    assign out_data   = state_q;
    assign lockup_fix = lockup_fix_q;
    assign hs         = out_valid & out_ready;
    // An all-ones seed would freeze the register, so fall back to SEED
    assign load_val   = (seed_data == LOCKUP) ? SEED : seed_data;

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        lockup_fix_d = 1'b0;
        if (seed_load) begin
            state_d      = load_val;
            fsm_d        = IDLE;
            lockup_fix_d = (seed_data == LOCKUP);
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (en) fsm_d = RUN;
                end
                RUN: begin
                    if (hs) begin
                        state_d = step_chain[STEPS];
                        if (!en) fsm_d = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q        <= IDLE;
            state_q      <= SEED;
            lockup_fix_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            lockup_fix_q <= lockup_fix_d;
        end
    end

`ifdef LFSR_PERIOD_MON_EN
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH:0]   cnt_q, cnt_d, pcnt_q, pcnt_d, cnt_inc;
    logic             wrap_q, wrap_d;

    assign period_wrap = wrap_q;
    assign period_cnt  = pcnt_q;
    assign cnt_inc     = cnt_q + (WIDTH+1)'(STEPS);

    // Wrap is judged at word boundaries against the last loaded start value
    always_comb begin
        start_d = start_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        wrap_d  = 1'b0;
        if (seed_load) begin
            start_d = load_val;
            cnt_d   = '0;
        end else if (hs) begin
            if (step_chain[STEPS] == start_q) begin
                wrap_d = 1'b1;
                pcnt_d = cnt_inc;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= SEED;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            wrap_q  <= wrap_d;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Bench for lfsr_prng_stream: STEPS=1 and STEPS=2 instances share stimulus and are
// compared each cycle against a word-level reference model plus directed literal checks.
module tb_lfsr_prng_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_data = 8'h00;
    logic       out_ready = 1'b0;

    logic [7:0] o_data [2];
    logic       o_valid[2];
    logic       o_fix  [2];
    logic       o_wrap [2];
    logic [8:0] o_pcnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .out_data   (o_data[0]),
        .out_valid  (o_valid[0]),
        .out_ready  (out_ready),
        .lockup_fix (o_fix[0])
`ifdef LFSR_PERIOD_MON_EN
        ,
        .period_wrap(o_wrap[0]),
        .period_cnt (o_pcnt[0])
`endif
    );

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(2)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .out_data   (o_data[1]),
        .out_valid  (o_valid[1]),
        .out_ready  (out_ready),
        .lockup_fix (o_fix[1])
`ifdef LFSR_PERIOD_MON_EN
        ,
        .period_wrap(o_wrap[1]),
        .period_cnt (o_pcnt[1])
`endif
    );

`ifndef LFSR_PERIOD_MON_EN
    assign o_wrap[0] = 1'b0;
    assign o_wrap[1] = 1'b0;
    assign o_pcnt[0] = 9'd0;
    assign o_pcnt[1] = 9'd0;
`endif

    // Reference model: words, run flag and period bookkeeping per instance
    logic [7:0] m_state[2];
    logic [7:0] m_start[2];
    bit         m_run  [2];
    bit         m_fix  [2];
    bit         m_wrap [2];
    int         m_cnt  [2];
    int         m_pcnt [2];
    int         steps_of[2] = '{1, 2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] s);
        logic fb;
        fb = ($countones(s & 8'hB8) % 2) == 0;
        return {s[6:0], fb};
    endfunction

    task automatic model_init();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 8'h01;
            m_start[k] = 8'h01;
            m_run[k]   = 0;
            m_fix[k]   = 0;
            m_wrap[k]  = 0;
            m_cnt[k]   = 0;
            m_pcnt[k]  = 0;
        end
    endtask

    task automatic model_update(input logic e, input logic l, input logic [7:0] sd, input logic r);
        for (int k = 0; k < 2; k++) begin
            m_fix[k]  = 0;
            m_wrap[k] = 0;
            if (l) begin
                m_fix[k]   = (sd == 8'hFF);
                m_state[k] = (sd == 8'hFF) ? 8'h01 : sd;
                m_start[k] = m_state[k];
                m_run[k]   = 0;
                m_cnt[k]   = 0;
            end else if (m_run[k]) begin
                if (r) begin
                    for (int s = 0; s < steps_of[k]; s++) m_state[k] = mstep(m_state[k]);
                    m_cnt[k] += steps_of[k];
                    if (m_state[k] == m_start[k]) begin
                        m_wrap[k] = 1;
                        m_pcnt[k] = m_cnt[k];
                        m_cnt[k]  = 0;
                    end
                    if (!e) m_run[k] = 0;
                end
            end else if (e) begin
                m_run[k] = 1;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_valid%0d", k), 32'(o_valid[k]), 32'(m_run[k]));
            chk($sformatf("model_data%0d", k), 32'(o_data[k]), 32'(m_state[k]));
            chk($sformatf("model_fix%0d", k), 32'(o_fix[k]), 32'(m_fix[k]));
`ifdef LFSR_PERIOD_MON_EN
            chk($sformatf("model_wrap%0d", k), 32'(o_wrap[k]), 32'(m_wrap[k]));
            chk($sformatf("model_pcnt%0d", k), 32'(o_pcnt[k]), 32'(m_pcnt[k]));
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge
    task automatic tick(input logic e, input logic l, input logic [7:0] sd, input logic r);
        en        = e;
        seed_load = l;
        seed_data = sd;
        out_ready = r;
        model_update(e, l, sd, r);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [7:0] exp_a[6];
        logic [7:0] exp_b[3];
        int         hs;
        exp_a = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        exp_b = '{8'h01, 8'h07, 8'h1E};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_data", 32'(o_data[0]), 32'h01);
        chk("rst_fix", 32'(o_fix[0]), 32'd0);
        chk("rst_pcnt", 32'(o_pcnt[0]), 32'd0);
        reset = 1'b1;
        model_init();

        // Free-run stream from reset
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b1);
            chk($sformatf("run_valid%0d", i), 32'(o_valid[0]), 32'd1);
            chk($sformatf("run_word%0d", i), 32'(o_data[0]), 32'(exp_a[i]));
            if (i < 3) chk($sformatf("step2_word%0d", i), 32'(o_data[1]), 32'(exp_b[i]));
        end

        // Backpressure hold
        tick(1'b1, 1'b1, 8'h01, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b0);
            chk($sformatf("hold_valid%0d", i), 32'(o_valid[0]), 32'd1);
            chk($sformatf("hold_data%0d", i), 32'(o_data[0]), 32'h01);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("release_word", 32'(o_data[0]), 32'h03);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("release_next", 32'(o_data[0]), 32'h07);

        // Lock-up seed replacement
        tick(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("lock_fix", 32'(o_fix[0]), 32'd1);
        chk("lock_valid", 32'(o_valid[0]), 32'd0);
        chk("lock_state", 32'(o_data[0]), 32'h01);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("lock_fix_drop", 32'(o_fix[0]), 32'd0);
        chk("lock_restart", 32'(o_data[0]), 32'h01);
        chk("lock_revalid", 32'(o_valid[0]), 32'd1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("lock_next", 32'(o_data[0]), 32'h03);

        // Seed load during a handshake discards the advance
        tick(1'b1, 1'b1, 8'h5A, 1'b1);
        chk("ld_hs_valid", 32'(o_valid[0]), 32'd0);
        chk("ld_hs_fix", 32'(o_fix[0]), 32'd0);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("ld_hs_word", 32'(o_data[0]), 32'h5A);
        chk("ld_hs_revalid", 32'(o_valid[0]), 32'd1);

        // Full period from seed 01
        tick(1'b1, 1'b1, 8'h01, 1'b1);
        hs = 0;
        for (int i = 0; i < 600 && hs < 255; i++) begin
            if (o_valid[0]) hs++;
            tick(1'b1, 1'b0, 8'h00, 1'b1);
        end
        chk("period_bound", 32'(hs), 32'd255);
        chk("period_back", 32'(o_data[0]), 32'h01);
`ifdef LFSR_PERIOD_MON_EN
        chk("period_wrap", 32'(o_wrap[0]), 32'd1);
        chk("period_cnt", 32'(o_pcnt[0]), 32'd255);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       e, l, r;
            logic [7:0] sd;
            e  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 19) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            r  = ($urandom_range(0, 1) == 1);
            tick(e, l, sd, r);
        end

        // Asynchronous reset mid-stream
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid[0]), 32'd0);
        chk("arst_data", 32'(o_data[0]), 32'h01);
        chk("arst_valid_b", 32'(o_valid[1]), 32'd0);
        chk("arst_pcnt", 32'(o_pcnt[0]), 32'd0);
        en        = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_init();
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        chk("arst_restart", 32'(o_data[0]), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_prng_stream.md
Name: lfsr_prng_stream

Overview:
- Parametrised XNOR-feedback Fibonacci LFSR pseudo-random generator with a valid/ready output stream, run enable, runtime seed load and lock-up protection.
- Successor to the fixed 8-bit free-running PRNG: generalised width, taps, seed and steps-per-word.
- Feeds test-pattern, scrambler and dither consumers that apply backpressure.

Parameters:
- WIDTH, 8, LFSR and output word width; legal 3..32.
- TAPS, 8'hB8, feedback tap mask (bit i set = state[i] feeds XNOR); popcount must be even; elaboration error otherwise.
- SEED, 8'h01, reset and fallback state; must not equal the all-ones lock-up state (elaboration error).
- STEPS, 1, LFSR shifts per accepted word (1..WIDTH), unrolled combinationally.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- seed_load  in  1  load seed_data this cycle.
- seed_data  in  WIDTH  seed value.
- out_data  out  WIDTH  current LFSR state.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- lockup_fix  out  1  one-cycle pulse: a loaded seed was replaced by SEED.

Behaviour:
- Reset (reset==0, async): state=SEED, FSM=IDLE, out_valid=0, lockup_fix=0; period outputs 0.
- Single step: fb = ~^(state & TAPS); next = {state[WIDTH-2:0], fb}. One accepted word applies STEPS single steps.
- Lock-up state is all-ones; even tap popcount makes it a fixed point.
- FSM states:
  - IDLE: out_valid=0. Moves to RUN when en=1; out_valid is first high one cycle after en is sampled high.
  - RUN: out_valid=1, out_data=state.
- RUN handshake (out_valid & out_ready): state advances STEPS steps at the same edge; the new word is visible next cycle (zero bubble, one word per cycle max).
- RUN without handshake: out_data and out_valid hold stable, regardless of en.
- en=0 in RUN: FSM goes to IDLE only on the handshake edge or when no word is pending. Valid is never retracted by en.
- seed_load=1 (any state, highest priority):
  - state <= seed_data, or SEED if seed_data is all-ones; in the replacement case lockup_fix pulses 1 the next cycle.
  - FSM -> IDLE, out_valid=0 next cycle. This is the only permitted valid retraction, and it discards any concurrent handshake (no advance).
- seed_load with en=1 held: out_valid returns 1 two cycles after the load edge and first presents the loaded seed.
- Period for a maximal TAPS: 2^WIDTH-1 distinct words, wrapping back to the start value.
- Reset mid-stream: immediate return to reset values; no partial word.

Optional Feature:
- Macro LFSR_PERIOD_MON_EN.
- Defined:
  - Adds outputs period_wrap (1 bit) and period_cnt (WIDTH+1 bits).
  - A step counter clears on reset and seed_load and increments by 1 per single LFSR step.
  - When the state re-equals the last loaded/reset start value: period_wrap pulses one cycle, period_cnt latches the count, and the counter clears.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - lockup constant function all_ones(width).
  - default_taps(width) table for widths 3..32.
  - FSM state typedef {IDLE, RUN}.
  - tap_popcount function for elaboration checks.
- Sub-module lfsr_step: purely combinational, parameters WIDTH/TAPS, one single-step next-state. STEPS instances are chained in a generate loop.

Test Plan:
- Reset, WIDTH=8, TAPS=8'hB8, SEED=8'h01, en=1, out_ready=1 -> out_valid rises one cycle after en; words 01,03,07,0F,1E,3D on consecutive cycles.
- Same config, out_ready low 5 cycles after first word -> out_data holds 01 and out_valid stays 1; release ready -> 03 next cycle, no skip or duplicate.
- seed_load=1, seed_data=8'hFF -> state=01, lockup_fix pulses once, out_valid 0 for a cycle then the stream restarts at 01.
- seed_load=1, seed_data=8'h5A during a handshake -> no advance; next valid word = 5A.
- STEPS=2, seed 01 -> words 01,07,1E.
- With LFSR_PERIOD_MON_EN, free-run from reset -> period_wrap pulses after 255 accepted words, period_cnt=255; then assert reset low mid-run -> out_valid=0 and state=01 asynchronously.
